// File: rtl/vs4x400_loader.sv
// vs4x400 write-side feeder: buffers the query vector, then interleaves each
// database element with its query element into packed 64-bit memory words.
module vs4x400_loader #(
    parameter int ADDR_W  = 12,
    parameter int MAX_DIM = 252
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic [7:0]        dim_size,
    input  logic [9:0]        vector_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [63:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_Q,
        LOAD_V,
        FLUSH
    } state_t;

    localparam logic [7:0] MAX_D = 8'(MAX_DIM);

    state_t            state;
    logic [7:0]        dim;
    logic [9:0]        count;
    logic [7:0]        elem;
    logic [9:0]        vec;
    logic [ADDR_W-1:0] waddr;
    logic [47:0]       stage;
    logic [7:0]        qbuf [MAX_DIM];

    logic [17:0] words;
    logic        bad;
    logic        take;
    logic        last_elem;
    logic        last_vec;
    logic [7:0]  qcur;
    logic [15:0] lane;

    assign words     = {8'd0, vector_count} * {12'd0, dim_size[7:2]};
    assign bad       = (dim_size == 8'd0) || (dim_size[1:0] != 2'd0)
                    || (dim_size > MAX_D) || (vector_count == 10'd0)
                    || (words > 18'd4096);
    assign take      = in_valid & in_ready;
    assign last_elem = (elem == dim - 8'd1);
    assign last_vec  = (vec == count - 10'd1);
    assign qcur      = qbuf[elem];
    assign lane      = {in_data, qcur};

    // Query storage carries no reset; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (state == LOAD_Q && take)
            qbuf[elem] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            dim       <= '0;
            count     <= '0;
            elem      <= '0;
            vec       <= '0;
            waddr     <= '0;
            stage     <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_load) begin
                        if (bad) begin
                            err <= 1'b1;
                        end else begin
                            state    <= LOAD_Q;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            dim      <= dim_size;
                            count    <= vector_count;
                            elem     <= '0;
                            vec      <= '0;
                            waddr    <= '0;
                        end
                    end
                end
                LOAD_Q: begin
                    if (take) begin
                        if (last_elem) begin
                            elem  <= '0;
                            state <= LOAD_V;
                        end else begin
                            elem <= elem + 8'd1;
                        end
                    end
                end
                LOAD_V: begin
                    if (take) begin
                        case (elem[1:0])
                            2'd0: stage[15:0]  <= lane;
                            2'd1: stage[31:16] <= lane;
                            2'd2: stage[47:32] <= lane;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_waddr <= waddr;
                                mem_wdata <= {lane, stage};
                                waddr     <= waddr + 1'b1;
                            end
                        endcase
                        if (last_elem) begin
                            elem <= '0;
                            if (last_vec) begin
                                state    <= FLUSH;
                                in_ready <= 1'b0;
                            end else begin
                                vec <= vec + 10'd1;
                            end
                        end else begin
                            elem <= elem + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vs4x400_loader.sv
// Directed bench for vs4x400_loader: start checks, packing, stalls,
// ignored restarts, capacity boundary and mid-load reset.
module tb_vs4x400_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_load = 1'b0;
    logic [7:0]  dim_size = '0;
    logic [9:0]  vector_count = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    vs4x400_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_load   (start_load),
        .dim_size     (dim_size),
        .vector_count (vector_count),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          wr_n = 0;
    int          done_n = 0;
    int          err_n = 0;
    int          last_we_cyc = 0;
    int          done_cyc = 0;
    logic [11:0] wr_addr [4096];
    logic [63:0] wr_data [4096];

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_n < 4096) begin
                wr_addr[wr_n] = mem_waddr;
                wr_data[wr_n] = mem_wdata;
            end
            wr_n++;
            last_we_cyc = cyc;
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (err) err_n++;
    end

    int passed = 0;
    int total = 0;
    int busy_drops = 0;
    int tmo = 0;

    logic [7:0] qv [252];
    logic [7:0] dbv [16384];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] exp_word(int dim, int v, int w);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++)
            r[16*k +: 16] = {dbv[v*dim + 4*w + k], qv[4*w + k]};
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!acc && n < 100) begin
            acc = in_ready;
            if (!busy) busy_drops++;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) tmo++;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int dim, input int cnt);
        start_load = 1'b1;
        dim_size = 8'(dim);
        vector_count = 10'(cnt);
        @(posedge clk);
        #1;
        start_load = 1'b0;
    endtask

    task automatic run_load(input string tag, input int dim, input int cnt,
                            input bit gap, input bit pulse);
        int n;
        int bad;
        int wpv;
        wpv = dim / 4;
        wr_n = 0;
        done_n = 0;
        err_n = 0;
        busy_drops = 0;
        tmo = 0;
        do_start(dim, cnt);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready"}, in_ready, 1);
        for (int d = 0; d < dim; d++) send_byte(qv[d], gap);
        for (int v = 0; v < cnt; v++) begin
            for (int d = 0; d < dim; d++) begin
                if (pulse && v == 0 && d == 2) begin
                    start_load = 1'b1;
                    dim_size = 8'd4;
                    vector_count = 10'd1;
                end
                send_byte(dbv[v*dim + d], gap);
                start_load = 1'b0;
            end
        end
        if (!gap) begin
            check({tag, "_flush_ready"}, in_ready, 0);
            check({tag, "_flush_we"}, mem_we, 1);
        end
        n = 0;
        while (done_n == 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_done_n"}, done_n, 1);
        check({tag, "_err_n"}, err_n, 0);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_writes"}, wr_n, cnt * wpv);
        check({tag, "_done_lat"}, done_cyc - last_we_cyc, 1);
        check({tag, "_busy_held"}, busy_drops, 0);
        check({tag, "_timeouts"}, tmo, 0);
        bad = 0;
        for (int i = 0; i < wr_n && i < 4096; i++) begin
            if (wr_addr[i] !== 12'(i)) bad++;
            else if (wr_data[i] !== exp_word(dim, i / wpv, i % wpv)) bad++;
        end
        check({tag, "_bad_words"}, bad, 0);
    endtask

    typedef struct {
        int dim;
        int cnt;
        bit exp_err;
    } start_vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_vec_t;

    start_vec_t sv [7];
    wr_vec_t    wv [4];

    initial begin
        sv[0] = '{6, 2, 1};
        sv[1] = '{0, 2, 1};
        sv[2] = '{8, 0, 1};
        sv[3] = '{252, 100, 1};
        sv[4] = '{255, 1, 1};
        sv[5] = '{68, 241, 1};
        sv[6] = '{128, 129, 1};
        wv[0] = '{12'd0, 64'h0204_0203_0202_0201};
        wv[1] = '{12'd1, 64'h0208_0207_0206_0205};
        wv[2] = '{12'd2, 64'hFE04_FE03_FE02_FE01};
        wv[3] = '{12'd3, 64'hFE08_FE07_FE06_FE05};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rejected starts
        wr_n = 0;
        for (int i = 0; i < 7; i++) begin
            do_start(sv[i].dim, sv[i].cnt);
            check($sformatf("rej%0d_err", i), err, sv[i].exp_err);
            check($sformatf("rej%0d_busy", i), busy, 0);
            check($sformatf("rej%0d_ready", i), in_ready, 0);
            @(posedge clk);
            #1;
            check($sformatf("rej%0d_err_pulse", i), err, 0);
        end
        check("rej_writes", wr_n, 0);

        // Basic packing
        for (int d = 0; d < 8; d++) qv[d] = 8'(d + 1);
        for (int i = 0; i < 8; i++) dbv[i] = 8'h02;
        for (int i = 8; i < 16; i++) dbv[i] = 8'hFE;
        run_load("t1", 8, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), wr_addr[i], wv[i].addr);
            check($sformatf("t1_data%0d", i), wr_data[i], wv[i].data);
        end

        run_load("t2", 8, 2, 1, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_data%0d", i), wr_data[i], wv[i].data);

        // Restart request mid-load must be ignored
        for (int i = 0; i < 24; i++) dbv[i] = 8'(8'h80 + i * 11);
        run_load("t5", 8, 3, 0, 1);

        // Largest legal image
        for (int d = 0; d < 252; d++) qv[d] = 8'(d * 5 + 1);
        for (int i = 0; i < 16380; i++) dbv[i] = 8'(i * 7 + 3);
        run_load("t4", 252, 65, 0, 0);
        check("t4_last_addr", wr_addr[4094], 4094);

        // Reset after two words
        for (int d = 0; d < 8; d++) qv[d] = 8'(d + 1);
        for (int i = 0; i < 32; i++) dbv[i] = 8'(i + 8'h40);
        wr_n = 0;
        done_n = 0;
        do_start(8, 4);
        for (int d = 0; d < 8; d++) send_byte(qv[d], 0);
        for (int d = 0; d < 8; d++) send_byte(dbv[d], 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_we", mem_we, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", in_ready, 0);
        check("t6_partial", wr_n, 2);
        repeat (3) @(negedge clk);
        check("t6_no_done", done_n, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        qv[0] = 8'h11; qv[1] = 8'h22; qv[2] = 8'h33; qv[3] = 8'h44;
        dbv[0] = 8'hA1; dbv[1] = 8'hB2; dbv[2] = 8'hC3; dbv[3] = 8'hD4;
        run_load("t6b", 4, 1, 0, 0);
        check("t6b_word", wr_data[0], 64'hD444_C333_B222_A111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
